multi_cycle_subtractor: RTL and testbench

MULTI_CYCLE_SUBTRACTOR -- requirements
Module: multi_cycle_subtractor

---
 rtl/sub_pkg.sv | 13 +
 rtl/full_sub_cell.sv | 13 +
 rtl/multi_cycle_subtractor.sv | 145 ++++++++++++++
 tb/tb_multi_cycle_subtractor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and default sizing for the multi-cycle subtractor.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/multi_cycle_subtractor.sv
// Digit-serial subtractor: resolves DIGIT bits per clock, LSB slice first,
// with the slice borrow carried between cycles in a register.
// Optional build macro SUB_SAT_EN clamps underflowing results to zero.
// WIDTH must be a multiple of DIGIT.
module multi_cycle_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int MSB   = WIDTH - 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_acc;
  logic [WIDTH-1:0]   diff_full;
  logic [WIDTH-1:0]   diff_final;
  logic [DIGIT-1:0]   a_slice, b_slice, slice_d;
  logic [DIGIT:0]     chain;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q, zero_q, ovf_q;
  logic               accept, release_result, last_step;

  assign accept         = in_valid & (state == IDLE);
  assign release_result = out_ready & (state == DONE);
  assign last_step      = (cnt == CNT_W'(STEPS - 1));

  // Operands are frozen in a_q/b_q, so the slice is picked by the step count.
  assign a_slice  = a_q[int'(cnt) * DIGIT +: DIGIT];
  assign b_slice  = b_q[int'(cnt) * DIGIT +: DIGIT];
  assign chain[0] = borrow_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub_cell u_cell (
      .x  (a_slice[i]),
      .y  (b_slice[i]),
      .bi (chain[i]),
      .d  (slice_d[i]),
      .bo (chain[i+1])
    );
  end

  // Merge the current slice into the partial difference.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    diff_full = diff_acc;
    diff_full[int'(cnt) * DIGIT +: DIGIT] = slice_d;
  end

  // Final result, optionally clamped when the subtraction underflows.
  always_comb begin
`ifdef SUB_SAT_EN
    diff_final = chain[DIGIT] ? '0 : diff_full;
`else
    diff_final = diff_full;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = RUN;
      RUN:     if (last_step)      state_nxt = DONE;
      DONE:    if (release_result) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-slice datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_acc <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt      <= '0;
            diff_acc <= '0;
          end
        end
        RUN: begin
          diff_acc <= diff_full;
          borrow_q <= chain[DIGIT];
          cnt      <= cnt + 1'b1;
          if (last_step) begin
            diff_q <= diff_final;
            bout_q <= chain[DIGIT];
            zero_q <= (diff_final == '0);
            // Overflow is judged on the unclamped difference.
            ovf_q  <= (a_q[MSB] != b_q[MSB]) & (diff_full[MSB] != a_q[MSB]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_cycle_subtractor.sv
// Self-checking bench for multi_cycle_subtractor (WIDTH=16, DIGIT=4).
// Honours SUB_SAT_EN to match the clamped build.
module tb_multi_cycle_subtractor;

  localparam int W     = 16;
  localparam int D     = 4;
  localparam int STEPS = W / D;
`ifdef SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         bout, zero, ovf;

  int checks = 0;
  int errors = 0;

  multi_cycle_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operands.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       output logic [W-1:0] d, output logic bo, output logic z,
                       output logic ov);
    logic [W:0]   r;
    logic [W-1:0] raw;
    r   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    raw = r[W-1:0];
    bo  = r[W];
    ov  = (av[W-1] != bv[W-1]) && (raw[W-1] != av[W-1]);
    d   = (SAT && bo) ? '0 : raw;
    z   = (d == '0);
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    int n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av; b = bv; bin = bi;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble operands while running; the result must not change.
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_done();
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(STEPS));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic bi);
    logic [W-1:0] d;
    logic bo, z, ov;
    model(av, bv, bi, d, bo, z, ov);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"},  32'(diff), 32'(d));
    check({tag, "_bout"},  32'(bout), 32'(bo));
    check({tag, "_zero"},  32'(zero), 32'(z));
    check({tag, "_ovf"},   32'(ovf),  32'(ov));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_out_valid", 32'(out_valid), 32'd0);
    check("consume_in_ready",  32'(in_ready),  32'd1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic bi);
    start_op(av, bv, bi);
    wait_done();
    check_result(tag, av, bv, bi);
    consume();
  endtask

  initial begin
    logic [W-1:0] hd;
    logic hbo, hz, hov;
    logic [W-1:0] qa[$], qb[$];
    logic         qbin[$];
    int           got, cyc, last_cyc;
    logic         acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);

    // Directed corner cases.
    directed("basic",      16'h1234, 16'h0234, 1'b0);
    directed("underflow",  16'h0000, 16'h0001, 1'b0);
    directed("signed_ovf", 16'h8000, 16'h0001, 1'b0);
    directed("eq_bin1",    16'h5A5A, 16'h5A5A, 1'b1);
    directed("eq_bin0",    16'h5A5A, 16'h5A5A, 1'b0);
    directed("pos_ovf",    16'h7FFF, 16'hFFFF, 1'b0);

    // Back-pressure in DONE with new operands offered.
    start_op(16'h1111, 16'h0222, 1'b0);
    wait_done();
    model(16'h1111, 16'h0222, 1'b0, hd, hbo, hz, hov);
    in_valid = 1'b1; a = 16'h4444; b = 16'h0404; bin = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_diff",     32'(diff),      32'(hd));
      check("hold_bout",     32'(bout),      32'(hbo));
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    wait_done();
    check_result("held_ops", 16'h4444, 16'h0404, 1'b1);
    consume();

    // Reset in the middle of RUN discards the operation.
    start_op(16'h9999, 16'h1111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_diff",  32'(diff),      32'd0);
    check("midrun_rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    repeat (STEPS + 2) begin
      @(negedge clk);
      check("midrun_no_result", 32'(out_valid), 32'd0);
    end
    directed("after_rst", 16'h0010, 16'h0001, 1'b0);

    // Streaming: 100 random operand sets, in_valid and out_ready held high.
    got = 0; cyc = 0; last_cyc = -1;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 100 && cyc < 2000) begin
      acc = in_ready;
      if (acc) begin
        qa.push_back(a); qb.push_back(b); qbin.push_back(bin);
      end
      if (out_valid === 1'b1) begin
        if (qa.size() == 0) begin
          check("stream_unexpected_result", 32'd1, 32'd0);
        end else begin
          model(qa.pop_front(), qb.pop_front(), qbin.pop_front(), hd, hbo, hz, hov);
          check("stream_diff", 32'(diff), 32'(hd));
          check("stream_bout", 32'(bout), 32'(hbo));
          check("stream_ovf",  32'(ovf),  32'(hov));
          if (last_cyc >= 0) check("stream_interval", 32'(cyc - last_cyc), 32'(STEPS + 2));
        end
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
    end
    check("stream_count", 32'(got), 32'd100);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
